mem_arbiter: RTL

//  Initiator side of the main-memory req/rec protocol. Accepts line-miss requests from icache and dcache,

---
 rtl/mem_arbiter_pkg.sv | 39 +++
 rtl/mem_lat_counter.sv | 31 +++
 rtl/mem_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter: physical line pointer, cache line,
// request owner and controller state encoding.
package mem_arbiter_pkg;

    localparam int unsigned TAG_W               = 22;
    localparam int unsigned IDX_W               = 6;
    localparam int unsigned OFFSET_W            = 4;
    localparam int unsigned LINE_W              = 128;
    localparam int unsigned MEM_LATENCY_DEFAULT = 5;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [IDX_W-1:0]    idx;
        logic [OFFSET_W-1:0] offset;
    } pptr_t;

    typedef logic [LINE_W-1:0] cacheline_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WB_WAIT  = 3'd1,
        ST_WB_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_ISSUE = 3'd4,
        ST_RESP     = 3'd5,
        ST_FILL     = 3'd6
    } memarb_state_e;

    // Two pointers name the same line when tag and index agree; the offset is irrelevant.
    function automatic logic same_line(input pptr_t a, input pptr_t b);
        return (a.tag == b.tag) && (a.idx == b.idx);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Memory latency down-counter shared by the writeback and read wait states.
module mem_lat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(LATENCY - 1);
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // High when the current decrement brings the count to zero.
    assign expire_c = (count <= CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Initiator side of the main-memory req/rec protocol: arbitrates icache/dcache line misses,
// emulates memory latency, issues optional victim writeback then the read, and returns the fill.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of dcache priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ic_req_valid,
    input  pptr_t      ic_req_addr,
    output logic       ic_gnt,
    output logic       ic_fill_en,
    output pptr_t      ic_fill_addr,
    output cacheline_t ic_fill_line,
    input  logic       dc_req_valid,
    input  pptr_t      dc_req_addr,
    input  logic       dc_wb_valid,
    input  pptr_t      dc_wb_addr,
    input  cacheline_t dc_wb_line,
    output logic       dc_gnt,
    output logic       dc_fill_en,
    output pptr_t      dc_fill_addr,
    output cacheline_t dc_fill_line,
    output logic       req_ren,
    output pptr_t      req_raddr,
    output logic       req_wen,
    output pptr_t      req_waddr,
    output cacheline_t req_wcacheline,
    input  logic       rec_en,
    input  pptr_t      rec_addr,
    input  cacheline_t rec_cacheline
);

    memarb_state_e state, state_nxt;
    owner_e        owner_q, grant_owner;
    pptr_t         addr_q, grant_addr, wb_addr_q;
    cacheline_t    wb_line_q;
    logic          pick_dc, pick_ic, grant, grant_wb;
    logic          cnt_load, cnt_dec, cnt_expire;
    logic          ren_nxt, wen_nxt, accept, ic_fill_nxt, dc_fill_nxt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e last_owner;

    // On contention the port that did not win last time is favoured.
    assign pick_dc = dc_req_valid && (!ic_req_valid || (last_owner == OWN_IC));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_IC;
        end else if (grant) begin
            last_owner <= grant_owner;
        end
    end
`else
    assign pick_dc = dc_req_valid;
`endif

    assign pick_ic     = ic_req_valid && !pick_dc;
    assign grant       = (state == ST_IDLE) && !rst && (pick_dc || pick_ic);
    assign grant_owner = pick_dc ? OWN_DC : OWN_IC;
    assign grant_addr  = pick_dc ? dc_req_addr : ic_req_addr;
    assign grant_wb    = pick_dc && dc_wb_valid;

    // Grant is visible in the sampling cycle itself.
    assign ic_gnt = grant && !pick_dc;
    assign dc_gnt = grant && pick_dc;

    mem_lat_counter #(
        .LATENCY (LATENCY)
    ) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .expire_c (cnt_expire)
    );

    // Issue pulses and fills are registered on entry to their states.
    always_comb begin
        state_nxt   = state;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        ren_nxt     = 1'b0;
        wen_nxt     = 1'b0;
        accept      = 1'b0;
        ic_fill_nxt = 1'b0;
        dc_fill_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    if (LATENCY == 1) begin
                        state_nxt = grant_wb ? ST_WB_ISSUE : ST_RD_ISSUE;
                        wen_nxt   = grant_wb;
                        ren_nxt   = !grant_wb;
                    end else begin
                        state_nxt = grant_wb ? ST_WB_WAIT : ST_RD_WAIT;
                        cnt_load  = 1'b1;
                    end
                end
            end
            ST_WB_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_expire) begin
                    state_nxt = ST_WB_ISSUE;
                    wen_nxt   = 1'b1;
                end
            end
            ST_WB_ISSUE: begin
                if (LATENCY == 1) begin
                    state_nxt = ST_RD_ISSUE;
                    ren_nxt   = 1'b1;
                end else begin
                    state_nxt = ST_RD_WAIT;
                    cnt_load  = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_expire) begin
                    state_nxt = ST_RD_ISSUE;
                    ren_nxt   = 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rec_en && same_line(rec_addr, addr_q)) begin
                    accept      = 1'b1;
                    state_nxt   = ST_FILL;
                    ic_fill_nxt = (owner_q == OWN_IC);
                    dc_fill_nxt = (owner_q == OWN_DC);
                end
            end
            ST_FILL: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            owner_q        <= OWN_IC;
            addr_q         <= '0;
            wb_addr_q      <= '0;
            wb_line_q      <= '0;
            req_ren        <= 1'b0;
            req_raddr      <= '0;
            req_wen        <= 1'b0;
            req_waddr      <= '0;
            req_wcacheline <= '0;
            ic_fill_en     <= 1'b0;
            ic_fill_addr   <= '0;
            ic_fill_line   <= '0;
            dc_fill_en     <= 1'b0;
            dc_fill_addr   <= '0;
            dc_fill_line   <= '0;
        end else begin
            state      <= state_nxt;
            req_ren    <= ren_nxt;
            req_wen    <= wen_nxt;
            ic_fill_en <= ic_fill_nxt;
            dc_fill_en <= dc_fill_nxt;
            if (grant) begin
                owner_q <= grant_owner;
                addr_q  <= grant_addr;
                if (grant_wb) begin
                    wb_addr_q <= dc_wb_addr;
                    wb_line_q <= dc_wb_line;
                end
            end
            // Address/data registers only move on an issue, so they hold between pulses.
            if (ren_nxt) begin
                req_raddr <= grant ? grant_addr : addr_q;
            end
            if (wen_nxt) begin
                req_waddr      <= grant ? dc_wb_addr : wb_addr_q;
                req_wcacheline <= grant ? dc_wb_line : wb_line_q;
            end
            if (accept) begin
                if (owner_q == OWN_DC) begin
                    dc_fill_addr <= addr_q;
                    dc_fill_line <= rec_cacheline;
                end else begin
                    ic_fill_addr <= addr_q;
                    ic_fill_line <= rec_cacheline;
                end
            end
        end
    end

endmodule
